mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for datapath load/store accesses. Accepts a request
//   (Address, Write, WrData), inserts WAIT_CYCLES wait states, commits writes
//   and returns read data with a one-cycle Ack pulse. Stands in for the native
//   Memory wherever a handshaked, non-zero-latency memory is needed.
// PARAMETERS
//   ADDR_W       16    request address width (MAR low bits)
//   DEPTH        1024  storage words, 32 bits each; power of 2, <= 2**ADDR_W
//   WAIT_CYCLES  2     wait states between accept and Ack; legal 0..15
// PORTS
//   CLK      in   1       clock; all state updates on posedge
//   RST      in   1       synchronous, active-high reset
//   Req      in   1       access request; sampled only in IDLE
//   Write    in   1       1 = store, 0 = load; sampled with Req
//   Address  in   ADDR_W  word address; sampled with Req
//   WrData   in   32      store data; sampled with Req
//   RdData   out  32      load data; valid in the Ack cycle, held until next load
//   Ack      out  1       one-cycle completion pulse
//   Busy     out  1       1 while a transaction is in flight (state != IDLE)
//   Err      out  1       present only with MEM_RESP_RANGE_CHECK_EN; see below
// BEHAVIOUR
//   Reset: state=IDLE, Ack=0, Busy=0, RdData=0, Err=0, wait count=0.
//     Storage contents are not reset. Reset overrides any in-flight access.
//   FSM IDLE -> WAIT -> RESP -> IDLE:
//     IDLE: Req=1 at edge k latches Address/Write/WrData; next state WAIT
//       (count=WAIT_CYCLES-1) or RESP when WAIT_CYCLES=0.
//     WAIT: count decrements each cycle; at count=0 next state RESP.
//     RESP: Ack=1 for exactly this cycle; next state IDLE.
//   Latency: Req sampled at edge k -> Ack high in cycle k+1+WAIT_CYCLES.
//   Store commits on the edge entering RESP; load RdData loaded on that edge.
//     Store leaves RdData unchanged.
//   Req, Write, Address, WrData ignored while Busy=1 (including RESP cycle);
//     Req held high -> one transaction per WAIT_CYCLES+2 cycles.
//   Req dropped mid-transaction: no effect; transaction completes normally.
//   Reset during WAIT: store not committed, no Ack issued.
//   Address decode: index = Address[log2(DEPTH)-1:0] (wraps modulo DEPTH).
// CONFIGURATION
//   MEM_RESP_RANGE_CHECK_EN defined: Err port exists. Address >= DEPTH ->
//     no store, RdData=0, Err=1 in the Ack cycle only; Err=0 otherwise.
//   Not defined: no Err port; out-of-range addresses wrap as above.
// STRUCTURE
//   Package mem_resp_pkg: state encoding constants (IDLE/WAIT/RESP),
//     WAIT_CNT_W=4, MAX_WAIT=15.
//   One sub-module: mem_resp_wait_ctr (loadable 4-bit down-counter, zero flag).
//   Storage array and FSM stay in mem_responder.
// TESTING
//   Store 0xDEADBEEF @0x0010, WAIT=2, Req at k -> Busy k+1..k+3, Ack at k+3;
//     load 0x0010 -> RdData=0xDEADBEEF in Ack cycle.
//   Req held high with loads, WAIT=2 -> Ack every 4 cycles, no lost/extra Acks.
//   Store 0x1 @0x0020 (old 0x0), RST in WAIT -> no Ack; load 0x0020 = 0x0.
//   WAIT_CYCLES=0 -> Ack exactly one cycle after Req sample; Req high 1 cycle
//     with WAIT=3 -> Ack still at k+4.
//   Macro off, DEPTH=1024: store 0x1234 @0x0405 -> load 0x0005 = 0x1234.
//   Macro on: store @0x0405 -> Err=1, RdData=0 in Ack; 0x0005 unchanged.

Source files
------------

// File: rtl/mem_resp_pkg.sv
// Shared constants for the mem_responder slice: FSM state encoding and wait-counter sizing.
package mem_resp_pkg;

    localparam int WAIT_CNT_W = 4;
    localparam int MAX_WAIT   = 15;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/mem_resp_wait_ctr.sv
// Loadable down-counter that times the wait states; zero flag tells the FSM to respond.
module mem_resp_wait_ctr
    import mem_resp_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    input  logic                  dec,
    output logic [WAIT_CNT_W-1:0] count,
    output logic                  zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Handshaked memory responder: accepts one access in IDLE, waits WAIT_CYCLES, then pulses Ack.
// Define MEM_RESP_RANGE_CHECK_EN to add the Err port and block out-of-range accesses.
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req,
    input  logic              Write,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WrData,
    output logic [31:0]       RdData,
    output logic              Ack,
    output logic              Busy,
`ifdef MEM_RESP_RANGE_CHECK_EN
    output logic              Err,
`endif
    output logic [1:0]        dbg_state
);

    localparam int IDX_W      = $clog2(DEPTH);
    localparam int WAIT_CLAMP = (WAIT_CYCLES > MAX_WAIT) ? MAX_WAIT : WAIT_CYCLES;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD =
        (WAIT_CLAMP == 0) ? '0 : WAIT_CNT_W'(WAIT_CLAMP - 1);

    // Handshake: Req/Write/Address/WrData are sampled only when IDLE; Busy covers
    // every cycle from acceptance through the Ack cycle, so requests then are ignored.
    logic [1:0]            state;
    logic [1:0]            nxt;
    logic                  req_write;
    logic [ADDR_W-1:0]     req_addr;
    logic [31:0]           req_wdata;
    logic                  acc_write;
    logic [ADDR_W-1:0]     acc_addr;
    logic [31:0]           acc_wdata;
    logic                  acc_oor;
    logic                  enter_resp;
    logic                  ctr_load;
    logic                  ctr_dec;
    logic                  ctr_zero;
    logic [WAIT_CNT_W-1:0] wait_count_unused;
    logic [31:0]           mem [DEPTH];

    assign ctr_load = (state == IDLE) && Req;
    assign ctr_dec  = (state == WAIT) && !ctr_zero;

    mem_resp_wait_ctr u_wait_ctr (
        .clk      (CLK),
        .rst      (RST),
        .load     (ctr_load),
        .load_val (WAIT_LOAD),
        .dec      (ctr_dec),
        .count    (wait_count_unused),
        .zero     (ctr_zero)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (Req) nxt = (WAIT_CLAMP == 0) ? RESP : WAIT;
            WAIT:    if (ctr_zero) nxt = RESP;
            RESP:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // With zero wait states the commit edge is also the accept edge, so use the live inputs.
    always_comb begin
        if (state == IDLE) begin
            acc_write = Write;
            acc_addr  = Address;
            acc_wdata = WrData;
        end else begin
            acc_write = req_write;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
        end
    end

    assign enter_resp = (nxt == RESP) && (state != RESP);

`ifdef MEM_RESP_RANGE_CHECK_EN
    logic err_q;

    assign acc_oor = (32'(acc_addr) >= 32'(DEPTH));

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_q <= 1'b0;
        end else begin
            err_q <= enter_resp && acc_oor;
        end
    end

    assign Err = err_q;
`else
    logic addr_unused;

    assign addr_unused = ^acc_addr;
    assign acc_oor     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            req_write <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            RdData    <= '0;
        end else begin
            state <= nxt;
            if (ctr_load) begin
                req_write <= Write;
                req_addr  <= Address;
                req_wdata <= WrData;
            end
            if (enter_resp && !acc_write) begin
                RdData <= acc_oor ? '0 : mem[acc_addr[IDX_W-1:0]];
            end
        end
    end

    // Storage is deliberately not reset; a reset before the commit edge drops the store.
    always_ff @(posedge CLK) begin
        if (!RST && enter_resp && acc_write && !acc_oor) begin
            mem[acc_addr[IDX_W-1:0]] <= acc_wdata;
        end
    end

    assign Ack       = (state == RESP);
    assign Busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: timing/data reference model, expected queue and monitor.
module tb_mem_responder;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 1024;
    localparam int W_MAIN = 2;
`ifdef MEM_RESP_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    // ---------------- main DUT (WAIT_CYCLES = 2) ----------------
    logic              req, write;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata, rd;
    logic              ack, busy, err;
    logic [1:0]        dbg;

    mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(W_MAIN)) u_dut (
        .CLK(clk), .RST(rst), .Req(req), .Write(write), .Address(addr), .WrData(wdata),
        .RdData(rd), .Ack(ack), .Busy(busy),
`ifdef MEM_RESP_RANGE_CHECK_EN
        .Err(err),
`endif
        .dbg_state(dbg)
    );
`ifndef MEM_RESP_RANGE_CHECK_EN
    assign err = 1'b0;
`endif

    // ---------------- latency DUTs (WAIT_CYCLES = 0 and 3) ----------------
    logic              req_s [2];
    logic              write_s [2];
    logic [ADDR_W-1:0] addr_s [2];
    logic [31:0]       wdata_s [2];
    logic [31:0]       rd_s [2];
    logic              ack_s [2];
    logic              busy_s [2];
    logic              err_s [2];
    logic [1:0]        dbg_s [2];

    for (genvar g = 0; g < 2; g++) begin : g_lat
        mem_responder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .WAIT_CYCLES(g == 0 ? 0 : 3)) u_dut (
            .CLK(clk), .RST(rst), .Req(req_s[g]), .Write(write_s[g]), .Address(addr_s[g]),
            .WrData(wdata_s[g]), .RdData(rd_s[g]), .Ack(ack_s[g]), .Busy(busy_s[g]),
`ifdef MEM_RESP_RANGE_CHECK_EN
            .Err(err_s[g]),
`endif
            .dbg_state(dbg_s[g])
        );
`ifndef MEM_RESP_RANGE_CHECK_EN
        assign err_s[g] = 1'b0;
`endif
    end

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int ack_seen = 0;
    bit mon_en   = 1'b0;

    logic [32:0] exp_q[$];  // {err, rd_data} per completed access, in order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Accepts a request when idle; the response is due WAIT+1 edges after acceptance and
    // the next request can be taken WAIT+2 edges after acceptance.
    logic [31:0]       model_mem [DEPTH];
    int                busy_cnt = 0;
    int                prev_cnt;
    logic              pend_write;
    logic [ADDR_W-1:0] pend_addr;
    logic [31:0]       pend_wdata;
    logic [31:0]       last_rd = '0;

    task automatic model_commit();
        bit          oor;
        logic [31:0] r;
        oor = RC && (int'(pend_addr) >= DEPTH);
        r   = last_rd;
        if (pend_write) begin
            if (!oor) model_mem[int'(pend_addr) % DEPTH] = pend_wdata;
        end else begin
            r       = oor ? 32'h0 : model_mem[int'(pend_addr) % DEPTH];
            last_rd = r;
        end
        exp_q.push_back({oor, r});
    endtask

    always @(posedge clk) begin
        prev_cnt = busy_cnt;
        if (rst) begin
            busy_cnt = 0;
            last_rd  = '0;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end else if (req === 1'b1) begin
            busy_cnt   = W_MAIN + 1;
            pend_write = write;
            pend_addr  = addr;
            pend_wdata = wdata;
        end
        if (busy_cnt == 1 && prev_cnt != 1) model_commit();
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [32:0] e;
        if (mon_en) begin
            check("busy", 32'(busy), 32'(busy_cnt != 0));
            check("ack", 32'(ack), 32'(busy_cnt == 1));
            if (ack === 1'b1) ack_seen++;
            if (busy_cnt == 1) begin
                if (exp_q.size() == 0) begin
                    check("exp_q_empty_at_ack", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", rd, e[31:0]);
                    check("err", 32'(err), 32'(e[32]));
                end
            end else begin
                check("rd_hold", rd, last_rd);
                check("err_idle", 32'(err), 32'd0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        for (int i = 0; i < 40 && busy_cnt != 0; i++) @(negedge clk);
    endtask

    task automatic issue(input logic w, input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        req = 1'b1; write = w; addr = a; wdata = d;
        @(negedge clk);
        // Garbage on the bus while busy must be ignored.
        req = 1'b0; write = 1'($urandom); addr = ADDR_W'($urandom); wdata = $urandom;
        wait_idle();
    endtask

    task automatic lat_test(input int s, input logic w, input logic [ADDR_W-1:0] a,
                            input logic [31:0] d, input int exp_lat, input string tag);
        int cycles;
        @(negedge clk);
        req_s[s] = 1'b1; write_s[s] = w; addr_s[s] = a; wdata_s[s] = d;
        @(negedge clk);
        req_s[s] = 1'b0;
        cycles = 0;
        while (ack_s[s] !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({tag, "_latency"}, 32'(cycles), 32'(exp_lat));
        @(negedge clk);
        check({tag, "_ack_pulse"}, 32'(ack_s[s]), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int          start_acks;
        logic [31:0] old5;
        logic [31:0] exp405;

        rst = 1'b1; req = 1'b0; write = 1'b0; addr = '0; wdata = '0;
        for (int s = 0; s < 2; s++) begin
            req_s[s] = 1'b0; write_s[s] = 1'b0; addr_s[s] = '0; wdata_s[s] = '0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        check("reset_ack", 32'(ack), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rd", rd, 32'd0);
        check("reset_err", 32'(err), 32'd0);

        for (int i = 0; i < 32; i++) issue(1'b1, ADDR_W'(i), $urandom);

        // Store then load back a known word.
        issue(1'b1, 16'h0010, 32'hDEADBEEF);
        issue(1'b0, 16'h0010, 32'h0);
        check("load_deadbeef", rd, 32'hDEADBEEF);

        // Req held high with loads: one accepted access every WAIT+2 cycles.
        start_acks = ack_seen;
        @(negedge clk);
        req = 1'b1; write = 1'b0; addr = 16'(2); wdata = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            addr = ADDR_W'($urandom_range(0, 31));
        end
        req = 1'b0;
        wait_idle();
        check("held_req_acks", 32'(ack_seen - start_acks), 32'd4);

        // Reset during the wait states drops the store and the Ack.
        issue(1'b1, 16'h0020, 32'h0);
        @(negedge clk);
        req = 1'b1; write = 1'b1; addr = 16'h0020; wdata = 32'h1;
        @(negedge clk);
        req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        issue(1'b0, 16'h0020, 32'h0);
        check("reset_in_wait_load", rd, 32'h0);

        // Address 0x0405 wraps to word 5, or is rejected with range checking.
        old5   = model_mem[5];
        exp405 = RC ? old5 : 32'h1234;
        issue(1'b1, 16'h0405, 32'h1234);
        issue(1'b0, 16'h0005, 32'h0);
        check("addr_0405_word5", rd, exp405);

        // Randomized mix of loads/stores, including addresses beyond DEPTH.
        for (int i = 0; i < 80; i++) begin
            logic [ADDR_W-1:0] a;
            a = ($urandom_range(0, 3) == 0) ? ADDR_W'(16'h0400 + $urandom_range(0, 31))
                                            : ADDR_W'($urandom_range(0, 31));
            issue(1'($urandom_range(0, 1)), a, $urandom);
        end

        // Latency on the zero-wait and three-wait instances.
        lat_test(0, 1'b1, 16'h0033, 32'hCAFE0001, 0, "w0_store");
        lat_test(0, 1'b0, 16'h0033, 32'h0, 0, "w0_load");
        check("w0_load_data", rd_s[0], 32'hCAFE0001);
        lat_test(1, 1'b1, 16'h0044, 32'h5A5A0003, 3, "w3_store");
        lat_test(1, 1'b0, 16'h0044, 32'h0, 3, "w3_load");
        check("w3_load_data", rd_s[1], 32'h5A5A0003);

        wait_idle();
        repeat (3) @(negedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
